// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues one word read at a time to
// instruction memory over req/ack, and hands each fetched word (with its PC)
// to decode through a single valid/ready output register. Execute-stage
// redirects replace the PC and squash any read still outstanding.
`ifndef W_CPU
`define W_CPU 32
`endif

module fetch_unit #(
  parameter int          W        = `W_CPU,
  parameter logic [W-1:0] RESET_PC = W'(32'h0040_0000)
) (
  input  logic         clk,
  input  logic         rst,
  output logic         imem_req,
  output logic [W-1:0] imem_addr,
  input  logic         imem_ack,
  input  logic [W-1:0] imem_rdata,
  output logic         inst_valid,
  input  logic         inst_ready,
  output logic [W-1:0] inst,
  output logic [W-1:0] inst_pc,
  input  logic         redir_valid,
  input  logic [W-1:0] redir_pc,
  output logic         fetch_fault,
  output logic [31:0]  fetch_count
);

  typedef enum logic [1:0] {
    ISSUE = 2'd0,
    WAIT  = 2'd1,
    HOLD  = 2'd2,
    FAULT = 2'd3
  } state_e;

  state_e       state_q, state_d;
  logic [W-1:0] pc_q, pc_d;
  logic         squash_q, squash_d;
  logic         req_q, req_d;
  logic [W-1:0] addr_q, addr_d;
  logic         valid_q, valid_d;
  logic [W-1:0] inst_q, inst_d;
  logic [W-1:0] ipc_q, ipc_d;
  logic         fault_q, fault_d;
  logic [31:0]  count_q, count_d;

  // An ack only means something while a request is actually outstanding.
  logic ack;
  assign ack = req_q & imem_ack;

  // Next-state logic; a redirect overrides normal sequencing in every state.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    squash_d = squash_q;
    req_d    = req_q;
    addr_d   = addr_q;
    valid_d  = valid_q;
    inst_d   = inst_q;
    ipc_d    = ipc_q;
    fault_d  = fault_q;
    count_d  = count_q;

    if (redir_valid) begin
      pc_d    = redir_pc;
      valid_d = 1'b0;
      if (state_q == WAIT) begin
        if (ack) begin
          // Read completes on the redirect edge: just drop the data.
          req_d    = 1'b0;
          squash_d = 1'b0;
          state_d  = ISSUE;
        end else begin
          // Read still in flight: remember to throw its data away. A single
          // flag suffices since only one request can be outstanding.
          squash_d = 1'b1;
        end
      end else begin
        req_d   = 1'b0;
        state_d = ISSUE;
      end
    end else begin
      unique case (state_q)
        ISSUE: begin
          if (pc_q[1:0] != 2'b00) begin
            fault_d = 1'b1;
            state_d = FAULT;
          end else begin
            req_d   = 1'b1;
            addr_d  = pc_q;
            state_d = WAIT;
          end
        end
        WAIT: begin
          if (ack) begin
            req_d = 1'b0;
            if (squash_q) begin
              squash_d = 1'b0;
              state_d  = ISSUE;
            end else begin
              inst_d  = imem_rdata;
              ipc_d   = addr_q;
              valid_d = 1'b1;
              pc_d    = pc_q + W'(4);
              state_d = HOLD;
            end
          end
        end
        HOLD: begin
          if (valid_q && inst_ready) begin
            valid_d = 1'b0;
            count_d = count_q + 32'd1;
            state_d = ISSUE;
          end
        end
        FAULT: begin
          req_d   = 1'b0;
          valid_d = 1'b0;
        end
        default: state_d = ISSUE;
      endcase
    end
  end

  // State register with synchronous reset that dominates every other input.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ISSUE;
      pc_q     <= RESET_PC;
      squash_q <= 1'b0;
      req_q    <= 1'b0;
      addr_q   <= '0;
      valid_q  <= 1'b0;
      inst_q   <= '0;
      ipc_q    <= '0;
      fault_q  <= 1'b0;
      count_q  <= 32'd0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      squash_q <= squash_d;
      req_q    <= req_d;
      addr_q   <= addr_d;
      valid_q  <= valid_d;
      inst_q   <= inst_d;
      ipc_q    <= ipc_d;
      fault_q  <= fault_d;
      count_q  <= count_d;
    end
  end

  assign imem_req    = req_q;
  assign imem_addr   = addr_q;
  assign inst_valid  = valid_q;
  assign inst        = inst_q;
  assign inst_pc     = ipc_q;
  assign fetch_fault = fault_q;
  assign fetch_count = count_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a per-cycle vector table (inputs applied
// before an edge, registered outputs expected after it) followed by
// hand-written sequences for PC wrap and reset in the middle of a read.
module tb_fetch_unit;

  localparam logic [31:0] A = 32'h0040_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        redir_valid;
  logic [31:0] redir_pc;
  logic        fetch_fault;
  logic [31:0] fetch_count;

  int checks = 0;
  int errors = 0;

  fetch_unit dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst(inst), .inst_pc(inst_pc),
    .redir_valid(redir_valid), .redir_pc(redir_pc),
    .fetch_fault(fetch_fault), .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst, ack, rdy, rv;
    logic [31:0] rdata, rpc;
    logic        ereq, evalid, efault;
    logic [31:0] eaddr, einst, eipc, ecount;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic r, logic a, logic [31:0] rd, logic y,
                              logic rv, logic [31:0] rp,
                              logic eq, logic [31:0] ea, logic ev,
                              logic [31:0] ei, logic [31:0] ep,
                              logic ef, logic [31:0] ec);
    vec_t v;
    v.rst = r; v.ack = a; v.rdata = rd; v.rdy = y; v.rv = rv; v.rpc = rp;
    v.ereq = eq; v.eaddr = ea; v.evalid = ev; v.einst = ei; v.eipc = ep;
    v.efault = ef; v.ecount = ec;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic a, input logic [31:0] rd,
                       input logic y, input logic rv, input logic [31:0] rp);
    rst = r; imem_ack = a; imem_rdata = rd; inst_ready = y;
    redir_valid = rv; redir_pc = rp;
    @(posedge clk);
    #1;
  endtask

  initial begin
    drive(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);

    //      rst ack rdata          rdy rv rpc          req addr       vld inst          ipc          flt cnt
    // reset, then zero-wait fetch of the first instruction
    tbl.push_back(mk(1,0,32'h0,          0,0,32'h0,        0,32'h0,    0,32'h0,        32'h0,       0,0));
    tbl.push_back(mk(1,0,32'h0,          0,0,32'h0,        0,32'h0,    0,32'h0,        32'h0,       0,0));
    tbl.push_back(mk(0,0,32'h0,          0,0,32'h0,        1,A,        0,32'h0,        32'h0,       0,0));
    tbl.push_back(mk(0,1,32'h2008_0005,  0,0,32'h0,        0,A,        1,32'h2008_0005,A,           0,0));
    tbl.push_back(mk(0,0,32'h0,          1,0,32'h0,        0,A,        0,32'h0,        32'h0,       0,1));
    tbl.push_back(mk(0,0,32'h0,          0,0,32'h0,        1,A+4,      0,32'h0,        32'h0,       0,1));
    // slow memory (4 idle WAIT cycles), then decode stalls 3 cycles
    for (int k = 0; k < 4; k++)
      tbl.push_back(mk(0,0,32'h0,        0,0,32'h0,        1,A+4,      0,32'h0,        32'h0,       0,1));
    tbl.push_back(mk(0,1,32'h8C09_0000,  0,0,32'h0,        0,A+4,      1,32'h8C09_0000,A+4,         0,1));
    for (int k = 0; k < 3; k++)
      tbl.push_back(mk(0,0,32'h0,        0,0,32'h0,        0,A+4,      1,32'h8C09_0000,A+4,         0,1));
    tbl.push_back(mk(0,0,32'h0,          1,0,32'h0,        0,A+4,      0,32'h0,        32'h0,       0,2));
    tbl.push_back(mk(0,0,32'h0,          0,0,32'h0,        1,A+8,      0,32'h0,        32'h0,       0,2));
    // redirect while waiting without ack: the late data must be squashed
    tbl.push_back(mk(0,0,32'h0,          0,1,A+32'h100,    1,A+8,      0,32'h0,        32'h0,       0,2));
    tbl.push_back(mk(0,0,32'h0,          0,0,32'h0,        1,A+8,      0,32'h0,        32'h0,       0,2));
    tbl.push_back(mk(0,1,32'hDEAD_BEEF,  0,0,32'h0,        0,A+8,      0,32'h0,        32'h0,       0,2));
    tbl.push_back(mk(0,0,32'h0,          0,0,32'h0,        1,A+32'h100,0,32'h0,        32'h0,       0,2));
    // redirect on the same edge as the ack
    tbl.push_back(mk(0,1,32'h1111_1111,  0,1,A+32'h180,    0,A+32'h100,0,32'h0,        32'h0,       0,2));
    tbl.push_back(mk(0,0,32'h0,          0,0,32'h0,        1,A+32'h180,0,32'h0,        32'h0,       0,2));
    tbl.push_back(mk(0,1,32'h2222_2222,  0,0,32'h0,        0,A+32'h180,1,32'h2222_2222,A+32'h180,   0,2));
    // redirect in HOLD with ready high: dropped, not counted
    tbl.push_back(mk(0,0,32'h0,          1,1,A+32'h200,    0,A+32'h180,0,32'h0,        32'h0,       0,2));
    tbl.push_back(mk(0,0,32'h0,          0,0,32'h0,        1,A+32'h200,0,32'h0,        32'h0,       0,2));
    tbl.push_back(mk(0,1,32'h3333_3333,  0,0,32'h0,        0,A+32'h200,1,32'h3333_3333,A+32'h200,   0,2));
    tbl.push_back(mk(0,0,32'h0,          1,0,32'h0,        0,A+32'h200,0,32'h0,        32'h0,       0,3));
    // misaligned redirect: fault at next ISSUE, stray ack ignored
    tbl.push_back(mk(0,0,32'h0,          0,1,A+32'h102,    0,A+32'h200,0,32'h0,        32'h0,       0,3));
    tbl.push_back(mk(0,0,32'h0,          0,0,32'h0,        0,A+32'h200,0,32'h0,        32'h0,       1,3));
    tbl.push_back(mk(0,0,32'h0,          0,0,32'h0,        0,A+32'h200,0,32'h0,        32'h0,       1,3));
    tbl.push_back(mk(0,1,32'h4444_4444,  1,0,32'h0,        0,A+32'h200,0,32'h0,        32'h0,       1,3));
    // aligned redirect resumes fetching, fault stays sticky
    tbl.push_back(mk(0,0,32'h0,          0,1,A+32'h200,    0,A+32'h200,0,32'h0,        32'h0,       1,3));
    tbl.push_back(mk(0,0,32'h0,          0,0,32'h0,        1,A+32'h200,0,32'h0,        32'h0,       1,3));
    tbl.push_back(mk(0,1,32'h5555_5555,  0,0,32'h0,        0,A+32'h200,1,32'h5555_5555,A+32'h200,   1,3));
    tbl.push_back(mk(0,0,32'h0,          1,0,32'h0,        0,A+32'h200,0,32'h0,        32'h0,       1,4));
    // reset clears the fault and the counter
    tbl.push_back(mk(1,0,32'h0,          0,0,32'h0,        0,32'h0,    0,32'h0,        32'h0,       0,0));

    foreach (tbl[i]) begin
      drive(tbl[i].rst, tbl[i].ack, tbl[i].rdata, tbl[i].rdy, tbl[i].rv, tbl[i].rpc);
      chk($sformatf("v%0d.req",   i), {31'h0, imem_req},    {31'h0, tbl[i].ereq});
      chk($sformatf("v%0d.addr",  i), imem_addr,            tbl[i].eaddr);
      chk($sformatf("v%0d.valid", i), {31'h0, inst_valid},  {31'h0, tbl[i].evalid});
      chk($sformatf("v%0d.fault", i), {31'h0, fetch_fault}, {31'h0, tbl[i].efault});
      chk($sformatf("v%0d.count", i), fetch_count,          tbl[i].ecount);
      if (tbl[i].evalid || tbl[i].rst) begin
        chk($sformatf("v%0d.inst",  i), inst,    tbl[i].einst);
        chk($sformatf("v%0d.ipc",   i), inst_pc, tbl[i].eipc);
      end
    end

    // PC wrap: start at the top word, next fetch address wraps to 0
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'hFFFF_FFFC);
    begin : wait_req
      int n = 0;
      while (!imem_req && n < 20) begin
        drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        n++;
      end
      chk("wrap.req_seen", {31'h0, imem_req}, 32'h1);
    end
    chk("wrap.addr", imem_addr, 32'hFFFF_FFFC);
    drive(1'b0, 1'b1, 32'h6666_6666, 1'b0, 1'b0, 32'h0);
    chk("wrap.inst", inst, 32'h6666_6666);
    chk("wrap.ipc",  inst_pc, 32'hFFFF_FFFC);
    drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    chk("wrap.count", fetch_count, 32'd1);
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    chk("wrap.req",  {31'h0, imem_req}, 32'h1);
    chk("wrap.next", imem_addr, 32'h0);

    // reset mid-WAIT, with an ack the same edge that reset must override
    drive(1'b1, 1'b1, 32'h7777_7777, 1'b1, 1'b0, 32'h0);
    chk("rstw.req",   {31'h0, imem_req},   32'h0);
    chk("rstw.valid", {31'h0, inst_valid}, 32'h0);
    chk("rstw.count", fetch_count, 32'd0);
    drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    chk("rstw.req2",  {31'h0, imem_req}, 32'h1);
    chk("rstw.addr",  imem_addr, A);
    drive(1'b0, 1'b1, 32'h2008_0005, 1'b0, 1'b0, 32'h0);
    chk("rstw.inst",  inst, 32'h2008_0005);
    chk("rstw.ipc",   inst_pc, A);
    drive(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
    chk("rstw.count2", fetch_count, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
